// File: rtl/snake_sequencer_pkg.sv
// Shared game types for the snake sequencer: headings, FSM states, LFSR seed.
package snake_sequencer_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } direction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic direction_t opposite(input direction_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_sequencer_apple_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that walks candidate apple cells.
module apple_lfsr
    import snake_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       advance,
    output logic [7:0] value
);

    logic feedback;

    // Primitive polynomial: from a non-zero seed the register never reaches zero.
    assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= {value[6:0], feedback};
        end
    end

endmodule

// File: rtl/snake_sequencer.sv
// Game control FSM: move timing, heading queue, apple placement search and end-of-game detection.
module snake_sequencer
    import snake_sequencer_pkg::*;
#(
    parameter int unsigned  MAX_LENGTH  = 30,
    parameter logic [23:0]  BASE_PERIOD = 24'd5_000_000,
    parameter logic [23:0]  MIN_PERIOD  = 24'd1_000_000,
    parameter logic [23:0]  SPEED_STEP  = 24'd100_000
)
(
    input  logic        system_clk,
    input  logic        nreset,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic        dir_valid,
    input  direction_t  dir_req,
    input  logic        good_collision,
    input  logic        bad_collision,
    input  logic [7:0]  score,
    input  logic        apple_occupied,
    output logic        step,
    output logic        grow,
    output logic        clear,
    output direction_t  direction,
    output game_state_t state,
    output logic        game_over,
    output logic [3:0]  apple_x,
    output logic [3:0]  apple_y,
    output logic [3:0]  probe_x,
    output logic [3:0]  probe_y
);

    game_state_t state_d;
    direction_t  dir_d, pend_dir_q, pend_dir_d;
    logic        pend_vld_q, pend_vld_d;
    logic [23:0] cnt_q, cnt_d, period_q, period_d;
    logic        search_q, search_d;
    logic [7:0]  probes_q, probes_d;
    logic [3:0]  apple_x_d, apple_y_d;
    logic        step_d, grow_d, clear_d;
    logic        active, terminal, search_busy, stepping;
    logic [7:0]  lfsr;
    logic        lfsr_adv;

    // Saturating move period; computed wide so score*SPEED_STEP cannot wrap.
    function automatic logic [23:0] calc_period(input logic [7:0] s);
        logic [32:0] dec;
        dec = 33'(s) * 33'(SPEED_STEP);
        if (dec + 33'(MIN_PERIOD) >= 33'(BASE_PERIOD)) return MIN_PERIOD;
        return BASE_PERIOD - dec[23:0];
    endfunction

    apple_lfsr u_lfsr (
        .clk     (system_clk),
        .nreset  (nreset),
        .advance (lfsr_adv),
        .value   (lfsr)
    );

    assign active      = (state == RUN) || (state == PAUSE);
    assign terminal    = (cnt_q == period_q - 24'd1);
    // A growth step launches a search next cycle; treat it as busy already.
    assign search_busy = search_q | (step & grow);
    assign lfsr_adv    = search_q & apple_occupied;
    assign probe_x     = search_q ? lfsr[7:4] : 4'd0;
    assign probe_y     = search_q ? lfsr[3:0] : 4'd0;
    assign game_over   = (state == OVER);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt_q;
        period_d   = period_q;
        dir_d      = direction;
        pend_dir_d = pend_dir_q;
        pend_vld_d = pend_vld_q;
        search_d   = search_q;
        probes_d   = probes_q;
        apple_x_d  = apple_x;
        apple_y_d  = apple_y;
        step_d     = 1'b0;
        grow_d     = 1'b0;
        clear_d    = 1'b0;
        stepping   = 1'b0;

        if (search_q) begin
            if (!apple_occupied) begin
                apple_x_d = lfsr[7:4];
                apple_y_d = lfsr[3:0];
                search_d  = 1'b0;
            end else begin
                probes_d = probes_q + 8'd1;
            end
        end
        if (step && grow && active) begin
            search_d = 1'b1;
            probes_d = 8'd0;
        end

        case (state)
            IDLE: begin
                if (start_btn) begin
                    state_d    = RUN;
                    clear_d    = 1'b1;
                    cnt_d      = 24'd0;
                    period_d   = calc_period(score);
                    search_d   = 1'b1;
                    probes_d   = 8'd0;
                    dir_d      = RIGHT;
                    pend_vld_d = 1'b0;
                end
            end
            RUN: begin
                if (pause_btn) begin
                    state_d = PAUSE;
                end else if (!terminal) begin
                    cnt_d = cnt_q + 24'd1;
                end else if (!search_busy) begin
                    if (bad_collision) begin
                        state_d = OVER;
                    end else begin
                        stepping = 1'b1;
                        step_d   = 1'b1;
                        grow_d   = good_collision;
                        cnt_d    = 24'd0;
                        period_d = calc_period(score);
                    end
                end
            end
            PAUSE: begin
                if (pause_btn) state_d = RUN;
            end
            default: begin
                if (start_btn) state_d = IDLE;
            end
        endcase

        // The step pulse is seen by the datapath before the game ends on length.
        if (step && active && ({24'd0, score} >= MAX_LENGTH)) state_d = OVER;
        if (search_q && apple_occupied && probes_q == 8'd255) state_d = OVER;
        if (state_d == OVER || state_d == IDLE) search_d = 1'b0;

        // Commit first so a request in the step cycle is judged against the new heading.
        if (active) begin
            if (stepping && pend_vld_q) begin
                dir_d      = pend_dir_q;
                pend_vld_d = 1'b0;
            end
            if (dir_valid && dir_req != opposite(dir_d)) begin
                pend_dir_d = dir_req;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge system_clk) begin
        if (!nreset) begin
            state      <= IDLE;
            cnt_q      <= 24'd0;
            period_q   <= BASE_PERIOD;
            direction  <= RIGHT;
            pend_dir_q <= RIGHT;
            pend_vld_q <= 1'b0;
            search_q   <= 1'b0;
            probes_q   <= 8'd0;
            apple_x    <= 4'd0;
            apple_y    <= 4'd0;
            step       <= 1'b0;
            grow       <= 1'b0;
            clear      <= 1'b0;
        end else begin
            state      <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            direction  <= dir_d;
            pend_dir_q <= pend_dir_d;
            pend_vld_q <= pend_vld_d;
            search_q   <= search_d;
            probes_q   <= probes_d;
            apple_x    <= apple_x_d;
            apple_y    <= apple_y_d;
            step       <= step_d;
            grow       <= grow_d;
            clear      <= clear_d;
        end
    end

endmodule
